tenbaset_tx_scheduler: RTL
==========================

// Module: tenbaset_tx_scheduler
// PURPOSE
//  Owns the 10BASE-T TD pair. Time-shares it between the normal-link-pulse (NLP) generator and MAC frame transmission.
//  Frames are accepted as a byte stream, Manchester-encoded at 2 clk20 cycles per bit and terminated with TP_IDL.
//  Enforces the inter-frame gap (IFG). Sits between the MAC TX path and the TD output pins.
// PARAMETERS
//  NLP_PERIOD   262144  clk20 cycles between NLP starts while idle (13.1 ms)
//  NLP_WIDTH    2       NLP high time in cycles (100 ns)
//  TPIDL_CYC    6       TP_IDL high time after the last bit (300 ns)
//  IFG_CYC      192     inter-frame gap in cycles (96 bit times)
// PORTS
//  clk20         in   1  20 MHz clock; only clock
//  rst           in   1  synchronous, active-high reset
//  tx_valid      in   1  MAC byte available
//  tx_data       in   8  MAC byte; sent LSB first
//  tx_last       in   1  qualifies tx_data as the final frame byte
//  tx_ready      out  1  1-cycle pulse: tx_data consumed this cycle
//  tx_busy       out  1  high from frame start through end of IFG
//  tx_underrun   out  1  1-cycle pulse: frame aborted, tx_valid low at byte boundary
//  Ethernet_TDp  out  1  differential TD+ (registered)
//  Ethernet_TDm  out  1  differential TD- (registered)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; NLP counter 0; shift register cleared.
//  - FSM states: IDLE, NLP, PRE, DATA, TPIDL, IFG.
//  - IDLE: NLP counter increments every cycle.
//    - tx_valid=1 -> go to PRE (macro defined) or DATA. Counter clears.
//    - Otherwise, counter==NLP_PERIOD-1 -> go to NLP. Counter clears.
//    - Both on the same cycle: the frame wins; no NLP is sent.
//  - NLP: lasts NLP_WIDTH cycles, then returns to IDLE. Pins TDp=1, TDm=0.
//    - tx_valid arriving during NLP waits until IDLE.
//  - Manchester encoding, per bit b:
//    - 1st cycle: TDp=~b, TDm=b. 2nd cycle: TDp=b, TDm=~b.
//    - So a 1 is a mid-bit low->high transition on TDp.
//    - One byte = 16 cycles.
//  - DATA byte load: at each byte boundary, tx_valid=1 -> load tx_data and pulse tx_ready in that same cycle.
//    - The captured tx_last marks the final byte.
//  - Underrun: tx_valid=0 at a byte boundary after the first byte and before the final byte was loaded.
//    - Pulse tx_underrun. Go to TPIDL immediately; no partial byte is sent.
//  - TPIDL: entered after the final bit. TDp=1, TDm=0 for TPIDL_CYC cycles, then IFG.
//  - IFG: both pins 0 for IFG_CYC cycles; tx_valid ignored. Then IDLE.
//    - NLP counter is held at 0 from frame start to end of IFG.
//  - Idle pins: TDp=0, TDm=0.
//  - Output latency: pins register the FSM/encoder outputs, so they lag the state by 1 cycle.
//  - tx_busy is high in PRE, DATA, TPIDL and IFG.
//  - rst mid-frame or mid-NLP: pins return to 0 on the next edge. No TP_IDL, no tx_underrun.
// CONFIGURATION
//  TENBASET_PREAMBLE_EN defined:
//    - PRE state sends 7x 0x55 then 0xD5 (SFD), 128 cycles, with no tx_ready pulses.
//    - The first MAC byte is loaded at the end of the SFD. tx_valid must still be high then, else underrun.
//  Undefined:
//    - PRE is unused; the MAC supplies preamble/SFD bytes itself.
//    - The first byte is loaded in the IDLE->DATA cycle.
// STRUCTURE
//  Package tenbaset_pkg:
//    - state enum; PREAMBLE_BYTE=8'h55; SFD_BYTE=8'hD5; PREAMBLE_LEN=7; BIT_CYC=2.
//  Sub-module tenbaset_manchester_ser:
//    - Inputs: byte load, byte, enable.
//    - Outputs: half-bit Manchester level and byte_done strobe (last cycle of bit 7).
//  Top holds the FSM, NLP counter, gap counters and output registers.
// TESTING
//  1. Idle after rst: TDp pulses high for exactly 2 cycles.
//     - Rising edges 262144 cycles apart; first at cycle 262144 after rst release (+1 register); TDm stays 0.
//  2. Single byte 0x01, tx_last=1, macro off:
//     - TDp sequence 0,1, 1,0, 1,0, 1,0, 1,0, 1,0, 1,0, 1,0 (TDm complementary).
//     - Then 6 cycles TDp=1/TDm=0, then 192 cycles both 0.
//     - tx_ready pulses once; tx_busy deasserts after IFG.
//  3. NLP expiry and tx_valid on the same cycle:
//     - No NLP emitted; frame starts.
//     - Next NLP is 262144 cycles after IFG end.
//  4. tx_valid rises during an NLP: frame starts in the cycle after the NLP's 2nd cycle; NLP not truncated.
//  5. 3-byte frame, tx_valid dropped before byte 2:
//     - tx_underrun pulses at the byte-2 boundary; TP_IDL follows immediately; byte 2 never seen on the pins.
//  6. Macro on, frame 0xAA:
//     - 64 bit times of alternating preamble, SFD 0xD5 (LSB first), then 0xAA.
//     - tx_ready pulses exactly 128 cycles after the start.
//     - rst mid-preamble drives the pins to 0 next edge.

Source files
------------

// File: rtl/tenbaset_pkg.sv
// Shared types and constants for the 10BASE-T TD-pair scheduler.
// Preamble generation in the scheduler is enabled with TENBASET_PREAMBLE_EN.
package tenbaset_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NLP,
    ST_PRE,
    ST_DATA,
    ST_TPIDL,
    ST_IFG
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 7;
  localparam int         BIT_CYC       = 2;
  localparam int         BYTE_CYC      = 8 * BIT_CYC;

endpackage

// File: rtl/tenbaset_manchester_ser.sv
// Byte-wide Manchester serializer: LSB first, two half-bit cycles per bit.
// o_level is the TD+ level for the current half bit; o_byte_done marks the last half of bit 7.
module tenbaset_manchester_ser
  import tenbaset_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_en,
  output logic       o_level,
  output logic       o_byte_done
);

  logic [7:0] r_sh;
  logic [2:0] r_bit;
  logic       r_half;

  // A load wins over the shift so a new byte can follow bit 7 without a gap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh   <= '0;
      r_bit  <= '0;
      r_half <= 1'b0;
    end else if (i_load) begin
      r_sh   <= i_byte;
      r_bit  <= '0;
      r_half <= 1'b0;
    end else if (i_en) begin
      r_half <= ~r_half;
      if (r_half) begin
        r_sh  <= {1'b0, r_sh[7:1]};
        r_bit <= r_bit + 3'd1;
      end
    end
  end

  assign o_level     = r_half ? r_sh[0] : ~r_sh[0];
  assign o_byte_done = i_en & r_half & (r_bit == 3'd7);

endmodule

// File: rtl/tenbaset_tx_scheduler.sv
// 10BASE-T TD-pair owner: NLP generation, Manchester frame transmit, TP_IDL and inter-frame gap.
// Define TENBASET_PREAMBLE_EN to have the block insert 7x 0x55 + SFD ahead of each frame.
module tenbaset_tx_scheduler
  import tenbaset_pkg::*;
#(
  parameter int NLP_PERIOD = 262144,
  parameter int NLP_WIDTH  = 2,
  parameter int TPIDL_CYC  = 6,
  parameter int IFG_CYC    = 192
) (
  input  logic       i_clk20,
  input  logic       i_rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_tx_busy,
  output logic       o_tx_underrun,
  output logic       o_Ethernet_TDp,
  output logic       o_Ethernet_TDm
);

  localparam int NLP_W = $clog2(NLP_PERIOD);
  localparam int GAP_W = 16;
  localparam logic [NLP_W-1:0] NLP_LAST  = NLP_W'(NLP_PERIOD - 1);
  localparam logic [GAP_W-1:0] NLP_END   = GAP_W'(NLP_WIDTH - 1);
  localparam logic [GAP_W-1:0] TPIDL_END = GAP_W'(TPIDL_CYC - 1);
  localparam logic [GAP_W-1:0] IFG_END   = GAP_W'(IFG_CYC - 1);
  localparam logic [2:0]       PRE_LAST  = 3'(PREAMBLE_LEN);
  localparam logic [2:0]       PRE_SFD   = 3'(PREAMBLE_LEN - 1);

  state_t           r_state, w_next;
  logic [NLP_W-1:0] r_nlp_cnt;
  logic [GAP_W-1:0] r_gap;
  logic [2:0]       r_pre_cnt;
  logic             r_last;
  logic             r_tdp, r_tdm;

  logic       w_load, w_ser_en, w_level, w_byte_done;
  logic [7:0] w_byte;
  logic       w_ready, w_underrun, w_tdp, w_tdm, w_busy;

  assign w_ser_en = (r_state == ST_PRE) || (r_state == ST_DATA);
  assign w_busy   = (r_state == ST_PRE) || (r_state == ST_DATA) ||
                    (r_state == ST_TPIDL) || (r_state == ST_IFG);

  tenbaset_manchester_ser u_ser (
    .i_clk       (i_clk20),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_byte      (w_byte),
    .i_en        (w_ser_en),
    .o_level     (w_level),
    .o_byte_done (w_byte_done)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_byte     = i_tx_data;
    w_ready    = 1'b0;
    w_underrun = 1'b0;
    w_tdp      = 1'b0;
    w_tdm      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A frame request beats an NLP that expires in the same cycle.
        if (i_tx_valid) begin
          w_load = 1'b1;
`ifdef TENBASET_PREAMBLE_EN
          w_byte = PREAMBLE_BYTE;
          w_next = ST_PRE;
`else
          w_ready = 1'b1;
          w_next  = ST_DATA;
`endif
        end else if (r_nlp_cnt == NLP_LAST) begin
          w_next = ST_NLP;
        end
      end
      ST_NLP: begin
        w_tdp = 1'b1;
        if (r_gap == NLP_END) w_next = ST_IDLE;
      end
      ST_PRE: begin
        w_tdp = w_level;
        w_tdm = ~w_level;
        if (w_byte_done) begin
          if (r_pre_cnt == PRE_LAST) begin
            if (i_tx_valid) begin
              w_load  = 1'b1;
              w_ready = 1'b1;
              w_next  = ST_DATA;
            end else begin
              w_underrun = 1'b1;
              w_next     = ST_TPIDL;
            end
          end else begin
            w_load = 1'b1;
            w_byte = (r_pre_cnt == PRE_SFD) ? SFD_BYTE : PREAMBLE_BYTE;
          end
        end
      end
      ST_DATA: begin
        w_tdp = w_level;
        w_tdm = ~w_level;
        if (w_byte_done) begin
          if (r_last) begin
            w_next = ST_TPIDL;
          end else if (i_tx_valid) begin
            w_load  = 1'b1;
            w_ready = 1'b1;
          end else begin
            w_underrun = 1'b1;
            w_next     = ST_TPIDL;
          end
        end
      end
      ST_TPIDL: begin
        w_tdp = 1'b1;
        if (r_gap == TPIDL_END) w_next = ST_IFG;
      end
      ST_IFG: begin
        if (r_gap == IFG_END) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk20) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_nlp_cnt <= '0;
      r_gap     <= '0;
      r_pre_cnt <= '0;
      r_last    <= 1'b0;
      r_tdp     <= 1'b0;
      r_tdm     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gap   <= (w_next != r_state) ? '0 : r_gap + GAP_W'(1);
      // The NLP counter keeps running through an NLP so starts stay exactly one period apart.
      if ((r_state == ST_IDLE) && (i_tx_valid || (r_nlp_cnt == NLP_LAST)))
        r_nlp_cnt <= '0;
      else if ((r_state == ST_IDLE) || (r_state == ST_NLP))
        r_nlp_cnt <= r_nlp_cnt + NLP_W'(1);
      else
        r_nlp_cnt <= '0;
      if (r_state != ST_PRE)
        r_pre_cnt <= '0;
      else if (w_byte_done)
        r_pre_cnt <= r_pre_cnt + 3'd1;
      if (w_ready) r_last <= i_tx_last;
      r_tdp <= w_tdp;
      r_tdm <= w_tdm;
    end
  end

  assign o_tx_ready     = w_ready & ~i_rst;
  assign o_tx_underrun  = w_underrun & ~i_rst;
  assign o_tx_busy      = w_busy & ~i_rst;
  assign o_Ethernet_TDp = r_tdp;
  assign o_Ethernet_TDm = r_tdm;

endmodule
